// File: rtl/spi_pkg.sv
// Shared constants for the SPI master: register map, CONTROL/STATUS bit positions
// and the transfer state encoding.
package spi_pkg;

   localparam logic [2:0] REG_RXDATA  = 3'd0;
   localparam logic [2:0] REG_TXDATA  = 3'd1;
   localparam logic [2:0] REG_STATUS  = 3'd2;
   localparam logic [2:0] REG_CONTROL = 3'd3;
   localparam logic [2:0] REG_CLKDIV  = 3'd4;
   localparam logic [2:0] REG_SSEL    = 3'd5;
   localparam logic [2:0] REG_LEVEL   = 3'd6;

   localparam int CTL_CPOL    = 0;
   localparam int CTL_CPHA    = 1;
   localparam int CTL_LSBF    = 2;
   localparam int CTL_SSO     = 3;
   localparam int CTL_IE_RRDY = 4;
   localparam int CTL_IE_TRDY = 5;
   localparam int CTL_IE_TMT  = 6;
   localparam int CTL_IE_ERR  = 7;
   localparam int CTL_LOOP    = 8;

   localparam int STS_RRDY = 0;
   localparam int STS_TRDY = 1;
   localparam int STS_TMT  = 2;
   localparam int STS_TOE  = 3;
   localparam int STS_ROE  = 4;
   localparam int STS_BUSY = 5;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_LEAD  = 3'd2,
      S_SHIFT = 3'd3,
      S_TRAIL = 3'd4
   } spi_state_e;

endpackage

// File: rtl/spi_fifo.sv
// Synchronous show-ahead FIFO; a push while full is accepted only when a pop
// frees the slot in the same cycle.
module spi_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic [DW-1:0] i_din,
   output logic [DW-1:0] o_dout,
   output logic          o_full,
   output logic          o_empty,
   output logic [AW:0]   o_count
);

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [AW:0]   r_cnt;
   logic          w_push;
   logic          w_pop;

   assign o_empty = (r_cnt == (AW+1)'(0));
   assign o_full  = (r_cnt == (AW+1)'(DEPTH));
   assign o_count = r_cnt;
   assign o_dout  = r_mem[r_rd];
   assign w_pop   = i_pop & ~o_empty;
   assign w_push  = i_push & (~o_full | w_pop);

   // Storage array, written on accepted pushes only.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr] <= i_din;
      end
   end

   // Pointer and occupancy tracking.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr  <= AW'(0);
         r_rd  <= AW'(0);
         r_cnt <= (AW+1)'(0);
      end else begin
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop)  r_rd <= r_rd + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
            2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/spi_master_fifo.sv
// Avalon-MM SPI master with TX/RX FIFOs and runtime mode/divider/slave-select.
// Optional internal loopback is built when SPIM_LOOPBACK_EN is defined.
module spi_master_fifo
   import spi_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int FIFO_D  = 8,
   parameter int NUM_SS  = 1,
   parameter int DIV_RST = 9
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        avs_addr,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [15:0]       avs_wdata,
   output logic [15:0]       avs_rdata,
   output logic              irq,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic [NUM_SS-1:0] ss_n
);

   localparam int CW = $clog2(FIFO_D) + 1;
   localparam int EW = 6;

   spi_state_e        r_state;
   spi_state_e        w_state_nx;
   logic [8:0]        r_ctrl;
   logic [7:0]        r_clkdiv;
   logic [NUM_SS-1:0] r_ssel;
   logic              r_toe;
   logic              r_roe;
   logic [15:0]       r_rdata;
   logic              r_irq;
   logic [DATA_W-1:0] r_last_rx;

   logic              r_cpha_l;
   logic              r_lsbf_l;
   logic [7:0]        r_div_l;
   logic [NUM_SS-1:0] r_ssel_l;
   logic [7:0]        r_div_cnt;
   logic [EW-1:0]     r_edge;
   logic [DATA_W-1:0] r_tx_sh;
   logic [DATA_W-1:0] r_rx_sh;
   logic              r_sclk;
   logic              r_mosi;
   logic [NUM_SS-1:0] r_ss_n;

   logic              w_wr_tx;
   logic              w_rd_rx;
   logic              w_tx_pop;
   logic              w_rx_push;
   logic              w_rx_pop;
   logic [DATA_W-1:0] w_tx_dout;
   logic [DATA_W-1:0] w_rx_dout;
   logic              w_tx_full;
   logic              w_tx_empty;
   logic              w_rx_full;
   logic              w_rx_empty;
   logic [CW-1:0]     w_tx_cnt;
   logic [CW-1:0]     w_rx_cnt;
   logic [15:0]       w_txc16;
   logic [15:0]       w_rxc16;
   logic              w_tick;
   logic              w_last_edge;
   logic              w_odd_edge;
   logic              w_sample;
   logic              w_shift;
   logic              w_sin;
   logic              w_loop_act;
   logic              w_loop_now;
   logic [DATA_W-1:0] w_tx_load;
   logic [DATA_W-1:0] w_rx_raw;
   logic [DATA_W-1:0] w_rx_word;
   logic [NUM_SS-1:0] w_sel_now;
   logic [NUM_SS-1:0] w_ss_mask;
   logic [15:0]       w_status;
   logic              w_unused;

   function automatic logic [DATA_W-1:0] f_rev(input logic [DATA_W-1:0] v);
      logic [DATA_W-1:0] r;
      for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
      return r;
   endfunction

   assign w_wr_tx   = avs_write & (avs_addr == REG_TXDATA);
   assign w_rd_rx   = avs_read  & (avs_addr == REG_RXDATA);
   assign w_tx_pop  = (r_state == S_LOAD);
   assign w_rx_pop  = w_rd_rx & ~w_rx_empty;

   spi_fifo #(.DW(DATA_W), .DEPTH(FIFO_D)) u_tx_fifo (
      .clk(clk), .reset_n(reset_n), .i_push(w_wr_tx), .i_pop(w_tx_pop),
      .i_din(avs_wdata[DATA_W-1:0]), .o_dout(w_tx_dout), .o_full(w_tx_full),
      .o_empty(w_tx_empty), .o_count(w_tx_cnt)
   );

   spi_fifo #(.DW(DATA_W), .DEPTH(FIFO_D)) u_rx_fifo (
      .clk(clk), .reset_n(reset_n), .i_push(w_rx_push), .i_pop(w_rx_pop),
      .i_din(w_rx_word), .o_dout(w_rx_dout), .o_full(w_rx_full),
      .o_empty(w_rx_empty), .o_count(w_rx_cnt)
   );

`ifdef SPIM_LOOPBACK_EN
   logic r_loop_l;
   assign w_loop_act = r_loop_l;
   assign w_loop_now = (r_state == S_LOAD) ? r_ctrl[CTL_LOOP] : r_loop_l;
   assign w_sin      = r_loop_l ? r_mosi : miso;
`else
   assign w_loop_act = 1'b0;
   assign w_loop_now = 1'b0;
   assign w_sin      = miso;
`endif

   // r_edge holds completed edges; the edge happening on this tick is r_edge+1.
   assign w_tick      = (r_div_cnt == 8'd0);
   assign w_last_edge = (r_edge == EW'(2*DATA_W-1));
   assign w_odd_edge  = ~r_edge[0];
   assign w_sample    = (r_state == S_SHIFT) & w_tick & (r_cpha_l ? ~w_odd_edge : w_odd_edge);
   assign w_shift     = (r_state == S_SHIFT) & w_tick &
                        (r_cpha_l ? (w_odd_edge & (r_edge != EW'(0))) : ~w_odd_edge);
   assign w_rx_raw    = w_sample ? {r_rx_sh[DATA_W-2:0], w_sin} : r_rx_sh;
   assign w_rx_word   = r_lsbf_l ? f_rev(w_rx_raw) : w_rx_raw;
   assign w_rx_push   = (r_state == S_SHIFT) & w_tick & w_last_edge;
   assign w_tx_load   = r_ctrl[CTL_LSBF] ? f_rev(w_tx_dout) : w_tx_dout;

   assign w_sel_now = (r_state == S_LOAD) ? r_ssel : r_ssel_l;
   assign w_ss_mask = (((r_state != S_IDLE) && !w_loop_now) ? w_sel_now : {NUM_SS{1'b0}}) |
                      (r_ctrl[CTL_SSO] ? r_ssel : {NUM_SS{1'b0}});

   assign w_status = {10'd0, (r_state != S_IDLE), r_roe, r_toe,
                      (w_tx_empty & (r_state == S_IDLE)), ~w_tx_full, ~w_rx_empty};
   assign w_txc16  = 16'(w_tx_cnt);
   assign w_rxc16  = 16'(w_rx_cnt);
   assign w_unused = ^{avs_wdata[15:9], r_ctrl[CTL_LOOP], w_txc16[15:8], w_rxc16[15:8]};

   // Transfer sequencing.
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE:  w_state_nx = w_tx_empty ? S_IDLE : S_LOAD;
         S_LOAD:  w_state_nx = S_LEAD;
         S_LEAD:  w_state_nx = w_tick ? S_SHIFT : S_LEAD;
         S_SHIFT: w_state_nx = (w_tick && w_last_edge) ? S_TRAIL : S_SHIFT;
         S_TRAIL: begin
            if (w_tick) w_state_nx = w_tx_empty ? S_IDLE : S_LOAD;
            else        w_state_nx = S_TRAIL;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // Shift engine: divider, edge counter, shifters and SPI pins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_cpha_l  <= 1'b0;
         r_lsbf_l  <= 1'b0;
         r_div_l   <= 8'(DIV_RST);
         r_ssel_l  <= NUM_SS'(1);
         r_div_cnt <= 8'd0;
         r_edge    <= EW'(0);
         r_tx_sh   <= {DATA_W{1'b0}};
         r_rx_sh   <= {DATA_W{1'b0}};
         r_sclk    <= 1'b0;
         r_mosi    <= 1'b0;
         r_ss_n    <= {NUM_SS{1'b1}};
`ifdef SPIM_LOOPBACK_EN
         r_loop_l  <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nx;
         r_ss_n  <= ~w_ss_mask;
         case (r_state)
            S_IDLE: begin
               r_sclk <= r_ctrl[CTL_CPOL];
               r_mosi <= 1'b0;
            end
            S_LOAD: begin
               r_cpha_l  <= r_ctrl[CTL_CPHA];
               r_lsbf_l  <= r_ctrl[CTL_LSBF];
               r_div_l   <= r_clkdiv;
               r_ssel_l  <= r_ssel;
               r_div_cnt <= r_clkdiv;
               r_edge    <= EW'(0);
               r_tx_sh   <= w_tx_load;
               r_rx_sh   <= {DATA_W{1'b0}};
               r_mosi    <= w_tx_load[DATA_W-1];
               r_sclk    <= r_ctrl[CTL_CPOL];
`ifdef SPIM_LOOPBACK_EN
               r_loop_l  <= r_ctrl[CTL_LOOP];
`endif
            end
            S_LEAD, S_SHIFT, S_TRAIL: begin
               r_div_cnt <= w_tick ? r_div_l : (r_div_cnt - 8'd1);
               if ((r_state == S_SHIFT) && w_tick) begin
                  r_edge <= r_edge + EW'(1);
                  if (!w_loop_act) r_sclk <= ~r_sclk;
               end
               if (w_sample) r_rx_sh <= w_rx_raw;
               if (w_shift) begin
                  r_tx_sh <= {r_tx_sh[DATA_W-2:0], 1'b0};
                  r_mosi  <= r_tx_sh[DATA_W-2];
               end
            end
            default: r_sclk <= r_sclk;
         endcase
      end
   end

   // Software-visible configuration and sticky error flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ctrl   <= 9'd0;
         r_clkdiv <= 8'(DIV_RST);
         r_ssel   <= NUM_SS'(1);
         r_toe    <= 1'b0;
         r_roe    <= 1'b0;
      end else begin
         if (avs_write) begin
            case (avs_addr)
`ifdef SPIM_LOOPBACK_EN
               REG_CONTROL: r_ctrl <= avs_wdata[8:0];
`else
               REG_CONTROL: r_ctrl <= {1'b0, avs_wdata[7:0]};
`endif
               REG_CLKDIV:  r_clkdiv <= avs_wdata[7:0];
               REG_SSEL:    r_ssel   <= avs_wdata[NUM_SS-1:0];
               REG_STATUS: begin
                  r_toe <= 1'b0;
                  r_roe <= 1'b0;
               end
               default:     r_ctrl <= r_ctrl;
            endcase
         end
         // A new overflow in the same cycle as a clearing write stays visible.
         if (w_wr_tx && w_tx_full && !w_tx_pop)   r_toe <= 1'b1;
         if (w_rx_push && w_rx_full && !w_rx_pop) r_roe <= 1'b1;
      end
   end

   // Registered read port and interrupt.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rdata   <= 16'd0;
         r_irq     <= 1'b0;
         r_last_rx <= {DATA_W{1'b0}};
      end else begin
         r_irq <= (w_status[STS_RRDY] & r_ctrl[CTL_IE_RRDY]) |
                  (w_status[STS_TRDY] & r_ctrl[CTL_IE_TRDY]) |
                  (w_status[STS_TMT]  & r_ctrl[CTL_IE_TMT])  |
                  ((r_toe | r_roe)    & r_ctrl[CTL_IE_ERR]);
         if (w_rx_pop) r_last_rx <= w_rx_dout;
         if (avs_read) begin
            case (avs_addr)
               REG_RXDATA:  r_rdata <= 16'(w_rx_empty ? r_last_rx : w_rx_dout);
               REG_STATUS:  r_rdata <= w_status;
               REG_CONTROL: r_rdata <= 16'(r_ctrl);
               REG_CLKDIV:  r_rdata <= {8'd0, r_clkdiv};
               REG_SSEL:    r_rdata <= 16'(r_ssel);
               REG_LEVEL:   r_rdata <= {w_rxc16[7:0], w_txc16[7:0]};
               default:     r_rdata <= 16'd0;
            endcase
         end
      end
   end

   assign avs_rdata = r_rdata;
   assign irq       = r_irq;
   assign sclk      = r_sclk;
   assign mosi      = r_mosi;
   assign ss_n      = r_ss_n;

endmodule
